// File: rtl/iob_cpu_bus_merge.sv
// ============================================================================
// iob_cpu_bus_merge: round-robin merge of ibus (m0) and dbus (m1) onto one
// IOb slave port, one outstanding read, zero added latency.   Rev 1.0
// ============================================================================
`default_nettype none

module iob_cpu_bus_merge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cke_i,

   input  logic                m0_avalid_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_wstrb_i,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic                m0_rvalid_o,
   output logic                m0_ready_o,

   input  logic                m1_avalid_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_wstrb_i,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                m1_rvalid_o,
   output logic                m1_ready_o,

   output logic                s_avalid_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [DATA_W/8-1:0] s_wstrb_o,
   input  logic [DATA_W-1:0]   s_rdata_i,
   input  logic                s_rvalid_i,
   input  logic                s_ready_i
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   gnt_q, gnt_d;
   logic   last_q, last_d;

   logic              any_req;
   logic              arb_sel;
   logic              sel;
   logic              req_v;
   logic              resp_v;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_wstrb;
   logic              sel_write;

   // On a tie the master not served most recently wins; otherwise whoever asks.
   assign any_req   = m0_avalid_i | m1_avalid_i;
   assign arb_sel   = (m0_avalid_i & m1_avalid_i) ? ~last_q : m1_avalid_i;
   assign sel       = (state_q == ST_IDLE) ? arb_sel : gnt_q;
   assign req_v     = ((state_q == ST_IDLE) & any_req) | (state_q == ST_REQ);
   assign resp_v    = (state_q == ST_RESP) & s_rvalid_i;
   assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
   assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
   assign sel_wstrb = sel ? m1_wstrb_i : m0_wstrb_i;
   assign sel_write = |sel_wstrb;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               if (s_ready_i) begin
                  last_d = sel;
                  if (!sel_write) begin
                     gnt_d   = sel;
                     state_d = ST_RESP;
                  end
               end else begin
                  // Grant is locked until the slave takes the request.
                  gnt_d   = sel;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (s_ready_i) begin
               last_d  = gnt_q;
               state_d = sel_write ? ST_IDLE : ST_RESP;
            end
         end
         ST_RESP: begin
            if (s_rvalid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
      end else if (cke_i) begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   // Every output is held at zero while reset is asserted.
   always_comb begin
      s_avalid_o  = ~rst_i & req_v;
      s_addr_o    = (rst_i | ~req_v) ? '0 : sel_addr;
      s_wdata_o   = (rst_i | ~req_v) ? '0 : sel_wdata;
      s_wstrb_o   = (rst_i | ~req_v) ? '0 : sel_wstrb;
      m0_ready_o  = ~rst_i & req_v & ~sel & s_ready_i;
      m1_ready_o  = ~rst_i & req_v &  sel & s_ready_i;
      m0_rvalid_o = ~rst_i & resp_v & ~gnt_q;
      m1_rvalid_o = ~rst_i & resp_v &  gnt_q;
      m0_rdata_o  = rst_i ? '0 : s_rdata_i;
      m1_rdata_o  = rst_i ? '0 : s_rdata_i;
   end

endmodule

`default_nettype wire

// File: tb/tb_iob_cpu_bus_merge.sv
// ============================================================================
// tb_iob_cpu_bus_merge: directed scenarios plus randomized traffic checked
// against a transaction-level arbiter model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_iob_cpu_bus_merge;

   logic             clk = 1'b0;
   logic             rst, cke;
   logic [1:0]       av;
   logic [1:0][31:0] ad, wd;
   logic [1:0][3:0]  ws;
   logic [31:0]      srdata;
   logic             srvalid, sready;

   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic        m0_rvalid, m1_rvalid, m0_ready, m1_ready, s_avalid;
   logic [3:0]  s_wstrb;

   int checks = 0;
   int passes = 0;

   // model: who holds a locked grant, who owns the outstanding read, last winner
   int lock_o = -1;
   int read_o = -1;
   bit last_m = 1'b1;
   logic [1:0] acc;

   iob_cpu_bus_merge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .cke_i(cke),
      .m0_avalid_i(av[0]), .m0_addr_i(ad[0]), .m0_wdata_i(wd[0]), .m0_wstrb_i(ws[0]),
      .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid), .m0_ready_o(m0_ready),
      .m1_avalid_i(av[1]), .m1_addr_i(ad[1]), .m1_wdata_i(wd[1]), .m1_wstrb_i(ws[1]),
      .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid), .m1_ready_o(m1_ready),
      .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
      .s_rdata_i(srdata), .s_rvalid_i(srvalid), .s_ready_i(sready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int pick();
      if (av == 2'b11) return last_m ? 0 : 1;
      if (av[0]) return 0;
      if (av[1]) return 1;
      return -1;
   endfunction

   task automatic compare_outputs();
      logic        e_sav;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_ws;
      logic [1:0]  e_rdy, e_rv;
      int          sel;
      e_sav = 1'b0; e_addr = '0; e_wd = '0; e_ws = '0; e_rdy = '0; e_rv = '0;
      if (!rst) begin
         if (read_o >= 0) begin
            if (srvalid) e_rv[read_o] = 1'b1;
         end else begin
            sel = (lock_o >= 0) ? lock_o : pick();
            if (sel >= 0) begin
               e_sav = 1'b1;
               e_addr = ad[sel]; e_wd = wd[sel]; e_ws = ws[sel];
               e_rdy[sel] = sready;
            end
         end
      end
      chk("s_avalid",  32'(s_avalid),  32'(e_sav));
      chk("m0_ready",  32'(m0_ready),  32'(e_rdy[0]));
      chk("m1_ready",  32'(m1_ready),  32'(e_rdy[1]));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
      chk("m0_rdata",  m0_rdata, rst ? 32'h0 : srdata);
      chk("m1_rdata",  m1_rdata, rst ? 32'h0 : srdata);
      if (rst || e_sav) begin
         chk("s_addr",  s_addr,  e_addr);
         chk("s_wdata", s_wdata, e_wd);
         chk("s_wstrb", 32'(s_wstrb), 32'(e_ws));
      end
   endtask

   task automatic update_model();
      int sel;
      if (rst) begin
         lock_o = -1; read_o = -1; last_m = 1'b1;
      end else if (cke) begin
         if (read_o >= 0) begin
            if (srvalid) read_o = -1;
         end else begin
            sel = (lock_o >= 0) ? lock_o : pick();
            if (sel >= 0) begin
               if (sready) begin
                  last_m = (sel == 1);
                  lock_o = -1;
                  if (ws[sel] == 4'h0) read_o = sel;
               end else begin
                  lock_o = sel;
               end
            end
         end
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle();
      #1;
      compare_outputs();
      acc = av & {m1_ready, m0_ready};
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; cke = 1'b1; av = '0; ad = '0; wd = '0; ws = '0;
      srdata = '0; srvalid = 1'b0; sready = 1'b0; acc = '0;
      @(negedge clk);
      cycle(); cycle();
      rst = 1'b0;

      // single ibus read, slave ready at once, data two cycles later
      av[0] = 1'b1; ad[0] = 32'h100; ws[0] = 4'h0; sready = 1'b1;
      #1 chk("t1_s_addr", s_addr, 32'h100); chk("t1_m0_ready", 32'(m0_ready), 32'd1);
      cycle();
      av[0] = 1'b0; sready = 1'b0;
      cycle();
      srvalid = 1'b1; srdata = 32'hDEADBEEF;
      #1 chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd1); chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
      cycle();
      srvalid = 1'b0;

      // simultaneous first requests after reset: m0 wins
      rst = 1'b1; cycle(); rst = 1'b0;
      av = 2'b11; ad[0] = 32'h10; ws[0] = 4'h0; ad[1] = 32'h20; wd[1] = 32'hAB; ws[1] = 4'hF;
      sready = 1'b1;
      #1 chk("t2_s_addr", s_addr, 32'h10); chk("t2_m1_ready", 32'(m1_ready), 32'd0);
      cycle();
      av[0] = 1'b0; srvalid = 1'b1;
      #1 chk("t2_resp_s_avalid", 32'(s_avalid), 32'd0);
      cycle();
      srvalid = 1'b0;
      #1 chk("t2_wr_addr", s_addr, 32'h20); chk("t2_wr_data", s_wdata, 32'hAB);
      cycle();
      av = 2'b11; ws[0] = 4'h3; ad[0] = 32'h14;
      #1 chk("t2_tie_m0_ready", 32'(m0_ready), 32'd1);
      cycle();
      av = 2'b00;

      // stalled slave keeps m1's grant locked
      av[1] = 1'b1; ad[1] = 32'h300; ws[1] = 4'h0; sready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin av[0] = 1'b1; ad[0] = 32'h400; ws[0] = 4'h0; end
         if (k == 3) sready = 1'b1;
         #1 chk("t3_s_addr", s_addr, 32'h300); chk("t3_m0_ready", 32'(m0_ready), 32'd0);
         cycle();
      end
      av[1] = 1'b0; sready = 1'b1;
      #1 chk("t3_resp_m0_ready", 32'(m0_ready), 32'd0);
      cycle();
      srvalid = 1'b1;
      cycle();
      srvalid = 1'b0;
      #1 chk("t3_m0_addr", s_addr, 32'h400); chk("t3_m0_served", 32'(m0_ready), 32'd1);
      cycle();
      av[0] = 1'b0; srvalid = 1'b1;
      cycle();
      srvalid = 1'b0;

      // back-to-back writes, slave always ready: strict alternation starting with m1
      av = 2'b11; ws[0] = 4'hF; ws[1] = 4'hF; sready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ad[0] = 32'h1000 + 32'(k); ad[1] = 32'h2000 + 32'(k);
         #1 chk("t4_m1_ready", 32'(m1_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("t4_s_avalid", 32'(s_avalid), 32'd1);
         cycle();
      end
      av = 2'b00;

      // reset during an outstanding read abandons it
      av[0] = 1'b1; ad[0] = 32'h500; ws[0] = 4'h0; sready = 1'b1;
      cycle();
      av[0] = 1'b0; sready = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0; srvalid = 1'b1; av[1] = 1'b1; ad[1] = 32'h600; ws[1] = 4'h0; sready = 1'b1;
      #1 chk("t5_m0_rvalid", 32'(m0_rvalid), 32'd0); chk("t5_m1_ready", 32'(m1_ready), 32'd1);
      cycle();
      av[1] = 1'b0; srvalid = 1'b1; sready = 1'b0;
      cycle();
      srvalid = 1'b0;

      // clock enable low while a read is outstanding
      av[0] = 1'b1; ad[0] = 32'h700; ws[0] = 4'h0; sready = 1'b1;
      cycle();
      cke = 1'b0; av = 2'b11; ad[1] = 32'h704; ws[1] = 4'h0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t6_s_avalid", 32'(s_avalid), 32'd0);
         cycle();
      end
      cke = 1'b1; srvalid = 1'b1;
      cycle();
      srvalid = 1'b0;

      // randomized traffic; masters hold each request until it is accepted
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!av[i] || acc[i]) begin
               av[i] = ($urandom_range(0, 2) != 0);
               ad[i] = $urandom;
               wd[i] = $urandom;
               ws[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
         end
         sready  = ($urandom_range(0, 9) < 6);
         srvalid = ($urandom_range(0, 9) < 3);
         srdata  = $urandom;
         rst     = ($urandom_range(0, 99) < 2);
         cke     = ($urandom_range(0, 9) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
